// File: rtl/gate_bist_ctrl_pkg.sv
// Shared definitions for the gate BIST sequencer: FSM state encoding and
// expected truth tables for common 2-input gates.
package gate_bist_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Bit i is the gate output for stim == i, with stim = {a, b}.
  localparam logic [3:0] EXP2_NAND = 4'b0111;
  localparam logic [3:0] EXP2_AND  = 4'b1000;
  localparam logic [3:0] EXP2_OR   = 4'b1110;
  localparam logic [3:0] EXP2_XOR  = 4'b0110;

  // The settle counter is loaded with settle-1, so it needs enough bits for that value.
  function automatic int settle_cnt_width(input int settle);
    return (settle <= 2) ? 1 : $clog2(settle);
  endfunction

endpackage

// File: rtl/gate_bist_ctrl_settle_cnt.sv
// Load/enable down-counter that raises zero once the programmed settle
// time has elapsed.
module gate_bist_ctrl_settle_cnt
  import gate_bist_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic zero
);

  localparam int CW = settle_cnt_width(SETTLE_CYCLES);
  localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/gate_bist_ctrl.sv
// BIST sequencer: sweeps every input pattern onto a combinational gate,
// waits a settle time per pattern and compares the response to a truth table.
module gate_bist_ctrl
  import gate_bist_ctrl_pkg::*;
#(
  parameter int                   N_IN          = 2,
  parameter int                   SETTLE_CYCLES = 2,
  parameter logic [2**N_IN-1:0]   EXPECTED      = EXP2_NAND
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [N_IN-1:0]      stim,
  input  logic                 resp,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2**N_IN-1:0]   fail_vec
);

  localparam int NPAT = 2**N_IN;
  localparam logic [N_IN-1:0] LAST_PAT = N_IN'(NPAT - 1);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("gate_bist_ctrl: SETTLE_CYCLES must be >= 1");
  end

  state_e            state_q, state_d;
  logic [N_IN-1:0]   p_q, p_d;
  logic [N_IN-1:0]   stim_q, stim_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [NPAT-1:0]   fail_vec_q, fail_vec_d;
  logic              cnt_load;
  logic              cnt_en;
  logic              cnt_zero;

  gate_bist_ctrl_settle_cnt #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .en   (cnt_en),
    .zero (cnt_zero)
  );

  always_comb begin
    state_d    = state_q;
    p_d        = p_q;
    stim_d     = stim_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    fail_vec_d = fail_vec_q;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        stim_d = '0;
        busy_d = 1'b0;
        if (start) begin
          state_d    = ST_SETTLE;
          p_d        = '0;
          fail_vec_d = '0;
          pass_d     = 1'b0;
          busy_d     = 1'b1;
          cnt_load   = 1'b1;
        end
      end

      ST_SETTLE: begin
        if (cnt_zero) begin
          state_d = ST_CHECK;
        end else begin
          cnt_en = 1'b1;
        end
      end

      ST_CHECK: begin
        fail_vec_d[p_q] = (resp != EXPECTED[p_q]);
        // Last pattern is found by compare so the index never wraps into a second pass.
        if (p_q == LAST_PAT) begin
          state_d = ST_DONE;
          stim_d  = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = ~|fail_vec_d;
        end else begin
          state_d  = ST_SETTLE;
          p_d      = p_q + N_IN'(1);
          stim_d   = p_q + N_IN'(1);
          cnt_load = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        stim_d  = '0;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      p_q        <= '0;
      stim_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_vec_q <= '0;
    end else begin
      state_q    <= state_d;
      p_q        <= p_d;
      stim_q     <= stim_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_vec_q <= fail_vec_d;
    end
  end

  assign stim     = stim_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign fail_vec = fail_vec_q;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Self-checking bench for gate_bist_ctrl: gate models on the response path,
// cycle-by-cycle expectations derived from pattern timing arithmetic.
module tb_gate_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic [1:0] stim0, stim1;
  logic       resp0;
  logic       resp1 = 1'b0;
  logic       busy0, done0, pass0, busy1, done1, pass1;
  logic [3:0] fail0, fail1;
  int         kind0 = 0;
  logic [3:0] rtbl0 = 4'h0;
  int         n_assert = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  // Gate models: 0 NAND, 1 AND, 2 OR, 3 XOR, 4 stuck-0, 5 stuck-1, else arbitrary table.
  function automatic logic gate_out(input int kind, input logic [1:0] s, input logic [3:0] tbl);
    logic a, b;
    a = s[1];
    b = s[0];
    case (kind)
      0:       return ~(a & b);
      1:       return a & b;
      2:       return a | b;
      3:       return a ^ b;
      4:       return 1'b0;
      5:       return 1'b1;
      default: return tbl[s];
    endcase
  endfunction

  function automatic logic nand_ref(input int i);
    return (((i / 2) % 2) == 1 && (i % 2) == 1) ? 1'b0 : 1'b1;
  endfunction

  assign resp0 = gate_out(kind0, stim0, rtbl0);

  gate_bist_ctrl dut0 (
    .clk(clk), .rst(rst), .start(start0), .stim(stim0), .resp(resp0),
    .busy(busy0), .done(done0), .pass(pass0), .fail_vec(fail0)
  );

  gate_bist_ctrl #(.SETTLE_CYCLES(4)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .stim(stim1), .resp(resp1),
    .busy(busy1), .done(done1), .pass(pass1), .fail_vec(fail1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One sweep on dut0. Cycle m = edges after the edge that sampled start;
  // each pattern occupies 3 cycles, so pattern k's result is visible from m = 3k+3.
  task automatic sweep0(input string name, input int kind, input logic [3:0] tbl,
                        input bit repulse, input int abort_at);
    logic [3:0] efail;
    logic [3:0] part;
    int         done_seen;
    efail = 4'h0;
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (gate_out(kind, 2'(i), tbl) !== nand_ref(i)) efail[i] = 1'b1;
    end
    kind0  = kind;
    rtbl0  = tbl;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int m = 0; m <= 12; m++) begin
      if (m == abort_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk({name, "_abort_stim"}, 32'(stim0), 0);
        chk({name, "_abort_busy"}, 32'(busy0), 0);
        chk({name, "_abort_done"}, 32'(done0), 0);
        chk({name, "_abort_pass"}, 32'(pass0), 0);
        chk({name, "_abort_fail"}, 32'(fail0), 0);
        for (int k = 0; k < 14; k++) begin
          tick();
          if (done0 !== 1'b0 || busy0 !== 1'b0) done_seen++;
        end
        chk({name, "_abort_quiet"}, 32'(done_seen), 0);
        $display("sweep %s kind=%0d aborted at cycle %0d", name, kind, m);
        return;
      end
      part = 4'h0;
      for (int k = 0; k < 4; k++) begin
        if (3 * (k + 1) <= m) part[k] = efail[k];
      end
      chk($sformatf("%s_stim_m%0d", name, m), 32'(stim0), (m < 12) ? 32'(m / 3) : 0);
      chk($sformatf("%s_busy_m%0d", name, m), 32'(busy0), (m < 12) ? 1 : 0);
      chk($sformatf("%s_done_m%0d", name, m), 32'(done0), (m == 12) ? 1 : 0);
      chk($sformatf("%s_pass_m%0d", name, m), 32'(pass0), (m == 12 && efail == 4'h0) ? 1 : 0);
      chk($sformatf("%s_fail_m%0d", name, m), 32'(fail0), 32'(part));
      start0 = repulse && (m == 4 || m == 12);
      tick();
    end
    start0 = 1'b0;
    chk({name, "_idle_stim"}, 32'(stim0), 0);
    chk({name, "_idle_busy"}, 32'(busy0), 0);
    chk({name, "_idle_done"}, 32'(done0), 0);
    chk({name, "_hold_pass"}, 32'(pass0), (efail == 4'h0) ? 1 : 0);
    chk({name, "_hold_fail"}, 32'(fail0), 32'(efail));
    $display("sweep %s kind=%0d fail_vec=%b pass=%b", name, kind, fail0, pass0);
  endtask

  initial begin
    logic [3:0] rt;
    int         rk;

    rst = 1'b1;
    repeat (3) tick();
    chk("rst_stim0", 32'(stim0), 0);
    chk("rst_busy0", 32'(busy0), 0);
    chk("rst_done0", 32'(done0), 0);
    chk("rst_pass0", 32'(pass0), 0);
    chk("rst_fail0", 32'(fail0), 0);
    chk("rst_stim1", 32'(stim1), 0);
    chk("rst_busy1", 32'(busy1), 0);
    chk("rst_fail1", 32'(fail1), 0);
    $display("reset released");
    rst = 1'b0;
    tick();

    sweep0("nand", 0, 4'h0, 1'b0, -1);
    sweep0("stuck1", 5, 4'h0, 1'b0, -1);
    sweep0("and", 1, 4'h0, 1'b0, -1);
    sweep0("repulse", 0, 4'h0, 1'b1, -1);
    tick();
    chk("repulse_no_restart", 32'(busy0), 0);
    sweep0("abort", 3, 4'h0, 1'b0, 5);
    sweep0("after_abort", 0, 4'h0, 1'b0, -1);

    for (int r = 0; r < 6; r++) begin
      rk = int'($urandom_range(0, 6));
      rt = 4'($urandom);
      sweep0($sformatf("rand%0d", r), rk, rt, 1'b0, -1);
    end

    // dut1: 5 cycles per pattern, resp is noise except in the check cycle (m % 5 == 4).
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int m = 0; m <= 20; m++) begin
      if (m < 20) begin
        chk($sformatf("s4_stim_m%0d", m), 32'(stim1), 32'(m / 5));
        chk($sformatf("s4_done_m%0d", m), 32'(done1), 0);
        chk($sformatf("s4_busy_m%0d", m), 32'(busy1), 1);
        resp1 = ((m % 5) == 4) ? nand_ref(int'(stim1)) : 1'($urandom_range(0, 1));
        tick();
      end else begin
        chk("s4_done", 32'(done1), 1);
        chk("s4_busy", 32'(busy1), 0);
        chk("s4_pass", 32'(pass1), 1);
        chk("s4_fail", 32'(fail1), 0);
      end
    end
    $display("sweep settle4 fail_vec=%b pass=%b", fail1, pass1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
